// File: rtl/rueckschreib_einheit_pkg.sv
// ---------------------------------------------------------------------------
// rueckschreib_einheit_pkg
// Shared constants and types for the writeback stage. Register file and
// decoder use the same widths and the same register-0 constant.
//   ADRESSBREITE   register address width
//   DATENBREITE    register data width
//   REGISTERANZAHL number of architectural registers
//   NULLREGISTER   hard-wired zero register (never written, never pending)
//   schreibQuelle_t which source filled the writeback output slot
// ---------------------------------------------------------------------------
package rueckschreib_einheit_pkg;

    localparam int ADRESSBREITE   = 6;
    localparam int DATENBREITE    = 32;
    localparam int REGISTERANZAHL = 2 ** ADRESSBREITE;
    localparam int NULLREGISTER   = 0;

    typedef enum logic [1:0] {
        QUELLE_KEINE = 2'd0,
        QUELLE_ALU   = 2'd1,
        QUELLE_LADEN = 2'd2
    } schreibQuelle_t;

endpackage

// File: rtl/rueckschreib_fifo.sv
// ---------------------------------------------------------------------------
// rueckschreib_fifo
// Synchronous FIFO buffering load results until the writeback port is free.
//   Clock, Reset   rising-edge clock, asynchronous active-high reset
//   Schieben       push EingangsDaten (ignored when full unless popping too)
//   Holen          pop the head entry (ignored when empty)
//   EingangsDaten  entry to push
//   KopfDaten      current head entry (valid when Leer=0)
//   Voll, Leer     occupancy flags
// TIEFE must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module rueckschreib_fifo #(
    parameter int TIEFE  = 4,
    parameter int BREITE = 38
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Schieben,
    input  logic              Holen,
    input  logic [BREITE-1:0] EingangsDaten,
    output logic [BREITE-1:0] KopfDaten,
    output logic              Voll,
    output logic              Leer
);

    localparam int ZB = $clog2(TIEFE);
    localparam int AB = ZB + 1;
    localparam logic [ZB-1:0] ZEIGER_EINS = ZB'(1);
    localparam logic [AB-1:0] ANZAHL_EINS = AB'(1);
    localparam logic [AB-1:0] ANZAHL_VOLL = AB'(TIEFE);

    logic [BREITE-1:0] speicher [TIEFE];
    logic [ZB-1:0]     schreibZeiger;
    logic [ZB-1:0]     leseZeiger;
    logic [AB-1:0]     anzahl;
    logic              schreiben;
    logic              lesen;

    assign Voll      = (anzahl == ANZAHL_VOLL);
    assign Leer      = (anzahl == '0);
    assign lesen     = Holen && !Leer;
    // A pop frees the slot on the same edge, so a full FIFO may still push.
    assign schreiben = Schieben && (!Voll || lesen);
    assign KopfDaten = speicher[leseZeiger];

    // NOTE: the storage array has no reset; only pointers and count define
    // validity, so stale contents are never observable.
    always_ff @(posedge Clock) begin
        if (schreiben) begin
            speicher[schreibZeiger] <= EingangsDaten;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            schreibZeiger <= '0;
            leseZeiger    <= '0;
            anzahl        <= '0;
        end else begin
            if (schreiben) begin
                schreibZeiger <= schreibZeiger + ZEIGER_EINS;
            end
            if (lesen) begin
                leseZeiger <= leseZeiger + ZEIGER_EINS;
            end
            case ({schreiben, lesen})
                2'b10:   anzahl <= anzahl + ANZAHL_EINS;
                2'b01:   anzahl <= anzahl - ANZAHL_EINS;
                default: anzahl <= anzahl;
            endcase
        end
    end

endmodule

// File: rtl/rueckschreib_einheit.sv
// ---------------------------------------------------------------------------
// rueckschreib_einheit
// Writeback stage: owns the register-file write port, merges single-cycle
// ALU results with buffered load results (ALU has priority) and tracks one
// pending-load bit per register for decoder stall decisions.
//   Clock, Reset                       clock, asynchronous active-high reset
//   AluGueltig/AluRegister/AluDaten    ALU result, no backpressure
//   SpeicherGueltig/SpeicherBereit     load-result handshake
//   SpeicherRegister/SpeicherDaten     load result payload
//   Reservieren/ReservierRegister      mark a register pending at load issue
//   ReservierBereit                    0 while that register is pending
//   QuellRegister1/2, Belegt1/2        decoder source lookup of pending bits
//   ZielRegister/ZielDaten/Schreibsignal registered register-file write port
// ---------------------------------------------------------------------------
module rueckschreib_einheit
    import rueckschreib_einheit_pkg::*;
#(
    parameter int TIEFE        = 4,
    parameter int DATENBREITE  = rueckschreib_einheit_pkg::DATENBREITE,
    parameter int ADRESSBREITE = rueckschreib_einheit_pkg::ADRESSBREITE
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    AluGueltig,
    input  logic [ADRESSBREITE-1:0] AluRegister,
    input  logic [DATENBREITE-1:0]  AluDaten,
    input  logic                    SpeicherGueltig,
    output logic                    SpeicherBereit,
    input  logic [ADRESSBREITE-1:0] SpeicherRegister,
    input  logic [DATENBREITE-1:0]  SpeicherDaten,
    input  logic                    Reservieren,
    input  logic [ADRESSBREITE-1:0] ReservierRegister,
    output logic                    ReservierBereit,
    input  logic [ADRESSBREITE-1:0] QuellRegister1,
    input  logic [ADRESSBREITE-1:0] QuellRegister2,
    output logic                    Belegt1,
    output logic                    Belegt2,
    output logic [ADRESSBREITE-1:0] ZielRegister,
    output logic [DATENBREITE-1:0]  ZielDaten,
    output logic                    Schreibsignal
);

    localparam int REGISTER      = 2 ** ADRESSBREITE;
    localparam int EINTRAGBREITE = ADRESSBREITE + DATENBREITE;
    localparam logic [ADRESSBREITE-1:0] REG_NULL = ADRESSBREITE'(NULLREGISTER);

    // ------------------------------------------------------------ load FIFO
    logic                     fifoVoll;
    logic                     fifoLeer;
    logic                     fifoSchieben;
    logic                     fifoHolen;
    logic [EINTRAGBREITE-1:0] kopfEintrag;
    logic [ADRESSBREITE-1:0]  kopfRegister;
    logic [DATENBREITE-1:0]   kopfDaten;

    assign SpeicherBereit = !fifoVoll;
    assign fifoSchieben   = SpeicherGueltig && SpeicherBereit;
    // The head is consumed whenever the ALU leaves the slot free, even for
    // register 0, so a zero-register load never blocks the queue.
    assign fifoHolen      = !AluGueltig && !fifoLeer;
    assign {kopfRegister, kopfDaten} = kopfEintrag;

    rueckschreib_fifo #(
        .TIEFE  (TIEFE),
        .BREITE (EINTRAGBREITE)
    ) ladePuffer (
        .Clock         (Clock),
        .Reset         (Reset),
        .Schieben      (fifoSchieben),
        .Holen         (fifoHolen),
        .EingangsDaten ({SpeicherRegister, SpeicherDaten}),
        .KopfDaten     (kopfEintrag),
        .Voll          (fifoVoll),
        .Leer          (fifoLeer)
    );

    // --------------------------------------------------------- output stage
    schreibQuelle_t quelleWahl;
    schreibQuelle_t ausgabeQuelle;

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        quelleWahl = QUELLE_KEINE;
        if (AluGueltig) begin
            quelleWahl = QUELLE_ALU;
        end else if (!fifoLeer) begin
            quelleWahl = QUELLE_LADEN;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ZielRegister  <= '0;
            ZielDaten     <= '0;
            Schreibsignal <= 1'b0;
            ausgabeQuelle <= QUELLE_KEINE;
        end else begin
            ausgabeQuelle <= quelleWahl;
            case (quelleWahl)
                QUELLE_ALU: begin
                    ZielRegister  <= AluRegister;
                    ZielDaten     <= AluDaten;
                    Schreibsignal <= (AluRegister != REG_NULL);
                end
                QUELLE_LADEN: begin
                    ZielRegister  <= kopfRegister;
                    ZielDaten     <= kopfDaten;
                    Schreibsignal <= (kopfRegister != REG_NULL);
                end
                default: begin
                    Schreibsignal <= 1'b0;
                end
            endcase
        end
    end

    // ----------------------------------------------------- pending scoreboard
    logic [REGISTER-1:0] belegtBits;
    logic [REGISTER-1:0] belegtNaechst;

    // Clear on the edge the register file captures a load write; a
    // reservation on the same edge is applied afterwards and therefore wins.
    // ALU writes never touch the pending bits.
    always_comb begin
        belegtNaechst = belegtBits;
        if (Schreibsignal && (ausgabeQuelle == QUELLE_LADEN)) begin
            belegtNaechst[ZielRegister] = 1'b0;
        end
        if (Reservieren && (ReservierRegister != REG_NULL)) begin
            belegtNaechst[ReservierRegister] = 1'b1;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            belegtBits <= '0;
        end else begin
            belegtBits <= belegtNaechst;
        end
    end

    // Bit 0 is never set, so register 0 reads as free everywhere.
    assign Belegt1         = belegtBits[QuellRegister1];
    assign Belegt2         = belegtBits[QuellRegister2];
    assign ReservierBereit = !belegtBits[ReservierRegister];

endmodule
